// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared constants and types for the fetch-stage PC sequencer.
//   FetchWidthPc   default width of every PC/address signal
//   FetchPcStep    default sequential fetch increment in bytes
//   FetchAlignBits low PC bits forced to zero on every redirect target
//   fetch_state_e  sequencer state encoding
package fetch_pc_ctrl_pkg;

    localparam int unsigned FetchWidthPc   = 32;
    localparam int unsigned FetchPcStep    = 4;
    localparam int unsigned FetchAlignBits = 2;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request handshake between the fetch sequencer and imem.
//   req   request valid, held until ack
//   addr  fetch address, stable while req && !ack
//   ack   fetch complete (may arrive in the same cycle as req)
// Modports: master = fetch sequencer side, slave = memory side.
interface fetch_pc_ctrl_if
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_PC = FetchWidthPc
) ();

    logic                req;
    logic [WIDTH_PC-1:0] addr;
    logic                ack;

    modport master (
        output req,
        output addr,
        input  ack
    );

    modport slave (
        input  req,
        input  addr,
        output ack
    );

endinterface

// File: rtl/fetch_pc_ctrl_pc_redirect_arb.sv
// Redirect arbiter for the fetch sequencer.
//   clk, rst_n           clock, asynchronous active-low reset
//   ex_redirect_i/_pc_i  EX redirect request and target (higher priority)
//   id_redirect_i/_pc_i  ID branch request and target
//   pend_load_i          capture the selected target into the pending register
//   redirect_o           some redirect is requested this cycle
//   target_o             selected, aligned target (combinational)
//   pend_target_o        last captured target, consumed when a drain completes
module fetch_pc_ctrl_pc_redirect_arb
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_PC = FetchWidthPc
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_redirect_i,
    input  logic [WIDTH_PC-1:0] ex_redirect_pc_i,
    input  logic                id_redirect_i,
    input  logic [WIDTH_PC-1:0] id_redirect_pc_i,
    input  logic                pend_load_i,
    output logic                redirect_o,
    output logic [WIDTH_PC-1:0] target_o,
    output logic [WIDTH_PC-1:0] pend_target_o
);

    localparam logic [WIDTH_PC-1:0] AlignMask =
        {{(WIDTH_PC - FetchAlignBits){1'b1}}, {FetchAlignBits{1'b0}}};

    logic [WIDTH_PC-1:0] pend_q, pend_d;

    // EX resolves older instructions than ID, so its redirect wins; the ID request is dropped.
    always_comb begin
        redirect_o = ex_redirect_i | id_redirect_i;
        target_o   = (ex_redirect_i ? ex_redirect_pc_i : id_redirect_pc_i) & AlignMask;
    end

    always_comb begin
        pend_d = pend_q;
        if (pend_load_i) begin
            pend_d = target_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_target_o = pend_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the fetch PC, drives the imem request handshake,
// applies EX/ID redirects and delivers (valid, pc) to the IF/ID boundary.
//   clk, rst_n           clock, asynchronous active-low reset
//   stall_i              decode hazard: hold delivered instr, no new request
//   id_redirect_i/_pc_i  ID branch taken and its target
//   ex_redirect_i/_pc_i  EX redirect and its target (wins over ID)
//   imem                 instruction-memory handshake (master side)
//   if_valid_o, if_pc_o  delivered instruction valid and its PC (registered)
//   flush_o              one-cycle IF/ID squash per accepted redirect (registered)
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned         WIDTH_PC = FetchWidthPc,
    parameter logic [WIDTH_PC-1:0] RESET_PC = '0,
    parameter int unsigned         PC_STEP  = FetchPcStep
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                id_redirect_i,
    input  logic [WIDTH_PC-1:0] id_redirect_pc_i,
    input  logic                ex_redirect_i,
    input  logic [WIDTH_PC-1:0] ex_redirect_pc_i,
    fetch_pc_ctrl_if.master     imem,
    output logic                if_valid_o,
    output logic [WIDTH_PC-1:0] if_pc_o,
    output logic                flush_o
);

    fetch_state_e        state_q, state_d;
    logic [WIDTH_PC-1:0] pc_q, pc_d;
    logic                if_valid_q, if_valid_d;
    logic [WIDTH_PC-1:0] if_pc_q, if_pc_d;
    logic                flush_q, flush_d;

    logic                redirect;
    logic                redirect_ok;
    logic [WIDTH_PC-1:0] target;
    logic [WIDTH_PC-1:0] pend_target;
    logic                req;
    logic [WIDTH_PC-1:0] addr;

    fetch_pc_ctrl_pc_redirect_arb #(
        .WIDTH_PC (WIDTH_PC)
    ) u_arb (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_redirect_i    (ex_redirect_i),
        .ex_redirect_pc_i (ex_redirect_pc_i),
        .id_redirect_i    (id_redirect_i),
        .id_redirect_pc_i (id_redirect_pc_i),
        .pend_load_i      (redirect_ok),
        .redirect_o       (redirect),
        .target_o         (target),
        .pend_target_o    (pend_target)
    );

    // Redirects are meaningless before the first fetch has been issued.
    assign redirect_ok = redirect && (state_q != StBoot);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = 1'b0;
        if_pc_d    = if_pc_q;
        flush_d    = redirect_ok;
        req        = 1'b0;
        addr       = '0;

        case (state_q)
            StBoot: begin
                state_d = StFetch;
            end

            StFetch: begin
                req  = 1'b1;
                addr = pc_q;
                if (redirect) begin
                    if (imem.ack) begin
                        // Returning instruction is wrong-path; drop it.
                        pc_d = target;
                    end else begin
                        // Request must not be withdrawn; finish it and discard.
                        state_d = StDrain;
                    end
                end else if (imem.ack) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    pc_d       = pc_q + WIDTH_PC'(PC_STEP);
                    if (stall_i) begin
                        state_d = StHold;
                    end
                end
            end

            StHold: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (stall_i) begin
                    if_valid_d = if_valid_q;
                end else begin
                    state_d = StFetch;
                end
            end

            StDrain: begin
                req  = 1'b1;
                addr = pc_q;
                if (imem.ack) begin
                    // A redirect in the ack cycle is newer than the latched one.
                    pc_d    = redirect ? target : pend_target;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            flush_q    <= flush_d;
        end
    end

    assign imem.req   = req;
    assign imem.addr  = addr;
    assign if_valid_o = if_valid_q;
    assign if_pc_o    = if_pc_q;
    assign flush_o    = flush_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: inputs change and outputs are sampled on the
// falling edge, with expected values worked out by hand per cycle.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        id_redirect_i = 1'b0;
    logic [31:0] id_redirect_pc_i = '0;
    logic        ex_redirect_i = 1'b0;
    logic [31:0] ex_redirect_pc_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic        flush_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_pc_ctrl_if #(.WIDTH_PC(32)) imem_bus ();

    fetch_pc_ctrl #(
        .WIDTH_PC (32),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .id_redirect_i    (id_redirect_i),
        .id_redirect_pc_i (id_redirect_pc_i),
        .ex_redirect_i    (ex_redirect_i),
        .ex_redirect_pc_i (ex_redirect_pc_i),
        .imem             (imem_bus),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .flush_o          (flush_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_req"},   32'(imem_bus.req), 32'h0);
        check_eq({tag, "_addr"},  imem_bus.addr,     32'h0);
        check_eq({tag, "_valid"}, 32'(if_valid_o),   32'h0);
        check_eq({tag, "_pc"},    if_pc_o,           32'h0);
        check_eq({tag, "_flush"}, 32'(flush_o),      32'h0);
    endtask

    // Leaves rst_n released on a falling edge; the following cycle is BOOT.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check_reset_outs("rst");
        tick();
        rst_n = 1'b1;
        check_eq("boot_req", 32'(imem_bus.req), 32'h0);
    endtask

    initial begin
        imem_bus.ack = 1'b0;

        // 1: zero-wait sequential fetch
        imem_bus.ack = 1'b1;
        do_reset();
        tick();
        check_eq("t1_req",   32'(imem_bus.req), 32'h1);
        check_eq("t1_addr",  imem_bus.addr,     32'h0);
        check_eq("t1_valid", 32'(if_valid_o),   32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t1_seq_valid", 32'(if_valid_o), 32'h1);
            check_eq("t1_seq_pc",    if_pc_o,         32'(4 * k));
            check_eq("t1_seq_addr",  imem_bus.addr,   32'(4 * k + 4));
        end

        // 2: three-cycle ack latency
        imem_bus.ack = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_wait_req",   32'(imem_bus.req), 32'h1);
            check_eq("t2_wait_addr",  imem_bus.addr,     32'h0);
            check_eq("t2_wait_valid", 32'(if_valid_o),   32'h0);
            if (i == 2) imem_bus.ack = 1'b1;
            tick();
        end
        imem_bus.ack = 1'b0;
        check_eq("t2_dlv_valid", 32'(if_valid_o), 32'h1);
        check_eq("t2_dlv_pc",    if_pc_o,         32'h0);
        check_eq("t2_dlv_addr",  imem_bus.addr,   32'h4);
        tick();
        check_eq("t2_pulse_end", 32'(if_valid_o), 32'h0);

        // 3: stall around delivery of 0x8
        imem_bus.ack = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        check_eq("t3_pre_pc",   if_pc_o,       32'h4);
        check_eq("t3_pre_addr", imem_bus.addr, 32'h8);
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t3_hold_req",   32'(imem_bus.req), 32'h0);
            check_eq("t3_hold_valid", 32'(if_valid_o),   32'h1);
            check_eq("t3_hold_pc",    if_pc_o,           32'h8);
        end
        stall_i = 1'b0;
        tick();
        check_eq("t3_rel_req",   32'(imem_bus.req), 32'h1);
        check_eq("t3_rel_addr",  imem_bus.addr,     32'hC);
        check_eq("t3_rel_valid", 32'(if_valid_o),   32'h0);
        tick();
        check_eq("t3_next_valid", 32'(if_valid_o), 32'h1);
        check_eq("t3_next_pc",    if_pc_o,         32'hC);

        // 4: simultaneous ID/EX redirect with ack; EX wins, target aligned
        id_redirect_i    = 1'b1;
        id_redirect_pc_i = 32'h100;
        ex_redirect_i    = 1'b1;
        ex_redirect_pc_i = 32'h203;
        tick();
        id_redirect_i = 1'b0;
        ex_redirect_i = 1'b0;
        check_eq("t4_flush", 32'(flush_o),     32'h1);
        check_eq("t4_valid", 32'(if_valid_o),  32'h0);
        check_eq("t4_addr",  imem_bus.addr,    32'h200);
        tick();
        check_eq("t4_flush_end", 32'(flush_o),    32'h0);
        check_eq("t4_dlv_valid", 32'(if_valid_o), 32'h1);
        check_eq("t4_dlv_pc",    if_pc_o,         32'h200);

        // 5: redirect while ack pending -> drain; second redirect during drain
        imem_bus.ack = 1'b0;
        do_reset();
        tick();
        check_eq("t5_addr0", imem_bus.addr, 32'h0);
        ex_redirect_i    = 1'b1;
        ex_redirect_pc_i = 32'h40;
        tick();
        ex_redirect_i = 1'b0;
        check_eq("t5_drain_flush", 32'(flush_o),     32'h1);
        check_eq("t5_drain_req",   32'(imem_bus.req), 32'h1);
        check_eq("t5_drain_addr",  imem_bus.addr,    32'h0);
        imem_bus.ack = 1'b1;
        tick();
        check_eq("t5_drop_valid", 32'(if_valid_o), 32'h0);
        check_eq("t5_flush_end",  32'(flush_o),    32'h0);
        check_eq("t5_new_addr",   imem_bus.addr,   32'h40);
        imem_bus.ack     = 1'b0;
        id_redirect_i    = 1'b1;
        id_redirect_pc_i = 32'h60;
        tick();
        check_eq("t5_d2_flush", 32'(flush_o),   32'h1);
        check_eq("t5_d2_addr",  imem_bus.addr,  32'h40);
        id_redirect_pc_i = 32'h80;
        tick();
        id_redirect_i = 1'b0;
        check_eq("t5_reflush",   32'(flush_o),    32'h1);
        check_eq("t5_d3_addr",   imem_bus.addr,   32'h40);
        check_eq("t5_d3_valid",  32'(if_valid_o), 32'h0);
        imem_bus.ack = 1'b1;
        tick();
        check_eq("t5_tgt_addr",  imem_bus.addr,   32'h80);
        check_eq("t5_tgt_flush", 32'(flush_o),    32'h0);
        check_eq("t5_tgt_valid", 32'(if_valid_o), 32'h0);
        tick();
        check_eq("t5_dlv_valid", 32'(if_valid_o), 32'h1);
        check_eq("t5_dlv_pc",    if_pc_o,         32'h80);

        // 6: PC wrap, then asynchronous reset in the middle of a drain
        ex_redirect_i    = 1'b1;
        ex_redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        ex_redirect_i = 1'b0;
        check_eq("t6_top_addr",  imem_bus.addr, 32'hFFFF_FFFC);
        check_eq("t6_top_flush", 32'(flush_o),  32'h1);
        tick();
        check_eq("t6_top_pc",   if_pc_o,       32'hFFFF_FFFC);
        check_eq("t6_wrap_addr", imem_bus.addr, 32'h0);
        imem_bus.ack     = 1'b0;
        id_redirect_i    = 1'b1;
        id_redirect_pc_i = 32'h300;
        tick();
        id_redirect_i = 1'b0;
        check_eq("t6_drain_flush", 32'(flush_o),      32'h1);
        check_eq("t6_drain_req",   32'(imem_bus.req), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("t6_async");
        // Redirect held through BOOT must be ignored.
        ex_redirect_i    = 1'b1;
        ex_redirect_pc_i = 32'h500;
        imem_bus.ack     = 1'b1;
        tick();
        rst_n = 1'b1;
        check_eq("t6_boot_req", 32'(imem_bus.req), 32'h0);
        tick();
        check_eq("t6_first_req",   32'(imem_bus.req), 32'h1);
        check_eq("t6_first_addr",  imem_bus.addr,     32'h0);
        check_eq("t6_first_flush", 32'(flush_o),      32'h0);
        ex_redirect_i = 1'b0;
        tick();
        check_eq("t6_dlv_valid", 32'(if_valid_o), 32'h1);
        check_eq("t6_dlv_pc",    if_pc_o,         32'h0);
        check_eq("t6_dlv_flush", 32'(flush_o),    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
